fp_dp3_operand_packer: RTL and testbench

//  Upstream feeder for the 3-term FP dot-product unit (z = a*b + c*d + e*f).
//  - Accepts a stream of FP element pairs (x,y) over valid/ready.
//  - Packs up to three consecutive pairs of one vector into operands a..f.
//  - Pads a short final group with +0.0.
//  - Presents each packed group on a registered valid/ready output, together with

---
 rtl/fp_dp3_operand_packer.sv | 181 ++++++++++++++++++
 tb/tb_fp_dp3_operand_packer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_dp3_operand_packer.sv
// Gathers up to three (x,y) FP element pairs of one vector into operands a..f
// for a 3-term dot-product unit, zero-padding a short final group.
module fp_dp3_operand_packer #(
    parameter int unsigned sig_width = 23,
    parameter int unsigned exp_width = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [sig_width+exp_width:0]   in_x_i,
    input  logic [sig_width+exp_width:0]   in_y_i,
    input  logic                           in_last_i,
    input  logic [2:0]                     in_rnd_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [sig_width+exp_width:0]   out_a_o,
    output logic [sig_width+exp_width:0]   out_b_o,
    output logic [sig_width+exp_width:0]   out_c_o,
    output logic [sig_width+exp_width:0]   out_d_o,
    output logic [sig_width+exp_width:0]   out_e_o,
    output logic [sig_width+exp_width:0]   out_f_o,
    output logic [1:0]                     out_count_o,
    output logic                           out_first_o,
    output logic                           out_last_o,
    output logic [2:0]                     out_rnd_o
);

    localparam int unsigned W = sig_width + exp_width + 1;

    // Collector state
    logic [W-1:0] slot_x_q [3];
    logic [W-1:0] slot_x_d [3];
    logic [W-1:0] slot_y_q [3];
    logic [W-1:0] slot_y_d [3];
    logic [1:0]   cnt_q, cnt_d;
    logic         full_q, full_d;
    logic         vstart_q, vstart_d;
    logic [2:0]   rnd_q, rnd_d;
    logic         grp_first_q, grp_first_d;
    logic         grp_last_q, grp_last_d;

    // Output register
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_a_q, out_a_d, out_b_q, out_b_d, out_c_q, out_c_d;
    logic [W-1:0] out_d_q, out_d_d, out_e_q, out_e_d, out_f_q, out_f_d;
    logic [1:0]   out_count_q, out_count_d;
    logic         out_first_q, out_first_d;
    logic         out_last_q, out_last_d;
    logic [2:0]   out_rnd_q, out_rnd_d;

    logic         xfer;
    logic         accept;
    logic [1:0]   wr_idx;

    // Next-state logic; a pair accepted during a transfer starts the next group in slot0
    always_comb begin
        xfer        = full_q & (~out_valid_q | out_ready_i);
        in_ready_o  = ~full_q | xfer;
        accept      = in_valid_i & in_ready_o;
        wr_idx      = xfer ? 2'd0 : cnt_q;

        slot_x_d    = slot_x_q;
        slot_y_d    = slot_y_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        vstart_d    = vstart_q;
        rnd_d       = rnd_q;
        grp_first_d = grp_first_q;
        grp_last_d  = grp_last_q;

        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_d_d     = out_d_q;
        out_e_d     = out_e_q;
        out_f_d     = out_f_q;
        out_count_d = out_count_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_rnd_d   = out_rnd_q;

        if (xfer) begin
            full_d      = 1'b0;
            cnt_d       = 2'd0;
            grp_first_d = 1'b0;
            grp_last_d  = 1'b0;
        end

        if (accept) begin
            slot_x_d[wr_idx] = in_x_i;
            slot_y_d[wr_idx] = in_y_i;
            cnt_d            = wr_idx + 2'd1;
            if (wr_idx == 2'd0) begin
                grp_first_d = vstart_q;
            end
            if (vstart_q) begin
                rnd_d = in_rnd_i;
            end
            vstart_d   = in_last_i;
            grp_last_d = in_last_i;
            full_d     = in_last_i | (wr_idx == 2'd2);
        end

        if (xfer) begin
            out_valid_d = 1'b1;
            out_a_d     = slot_x_q[0];
            out_b_d     = slot_y_q[0];
            out_c_d     = (cnt_q >= 2'd2) ? slot_x_q[1] : W'(0);
            out_d_d     = (cnt_q >= 2'd2) ? slot_y_q[1] : W'(0);
            out_e_d     = (cnt_q == 2'd3) ? slot_x_q[2] : W'(0);
            out_f_d     = (cnt_q == 2'd3) ? slot_y_q[2] : W'(0);
            out_count_d = cnt_q;
            out_first_d = grp_first_q;
            out_last_d  = grp_last_q;
            out_rnd_d   = rnd_q;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                slot_x_q[i] <= W'(0);
                slot_y_q[i] <= W'(0);
            end
            cnt_q       <= 2'd0;
            full_q      <= 1'b0;
            vstart_q    <= 1'b1;
            rnd_q       <= 3'd0;
            grp_first_q <= 1'b0;
            grp_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= W'(0);
            out_b_q     <= W'(0);
            out_c_q     <= W'(0);
            out_d_q     <= W'(0);
            out_e_q     <= W'(0);
            out_f_q     <= W'(0);
            out_count_q <= 2'd0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_rnd_q   <= 3'd0;
        end else begin
            slot_x_q    <= slot_x_d;
            slot_y_q    <= slot_y_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            vstart_q    <= vstart_d;
            rnd_q       <= rnd_d;
            grp_first_q <= grp_first_d;
            grp_last_q  <= grp_last_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            out_d_q     <= out_d_d;
            out_e_q     <= out_e_d;
            out_f_q     <= out_f_d;
            out_count_q <= out_count_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_rnd_q   <= out_rnd_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_a_o     = out_a_q;
    assign out_b_o     = out_b_q;
    assign out_c_o     = out_c_q;
    assign out_d_o     = out_d_q;
    assign out_e_o     = out_e_q;
    assign out_f_o     = out_f_q;
    assign out_count_o = out_count_q;
    assign out_first_o = out_first_q;
    assign out_last_o  = out_last_q;
    assign out_rnd_o   = out_rnd_q;

endmodule

// File: tb/tb_fp_dp3_operand_packer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// group-level reference model of the packer.
module tb_fp_dp3_operand_packer;

    typedef struct packed {
        logic [31:0] a, b, c, d, e, f;
        logic [1:0]  count;
        logic        first, last;
        logic [2:0]  rnd;
    } grp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready;
    logic [31:0] in_x, in_y;
    logic [2:0]  in_rnd;
    logic [31:0] oa, ob, oc, od, oe, of_;
    logic [1:0]  ocount;
    logic        ofirst, olast;
    logic [2:0]  ornd;

    int vectors = 0;
    int miscompares = 0;

    grp_t expq[$];
    grp_t obs[$];
    logic [31:0] cur_x[3], cur_y[3];
    int   cur_n = 0;
    logic cur_first = 1'b0;
    logic mvstart = 1'b1;
    logic [2:0] mrnd = 3'd0;
    logic prev_stall = 1'b0;
    grp_t prev_out;
    logic track_ready = 1'b0;
    int   ready_drops = 0;
    logic rand_done = 1'b0;

    fp_dp3_operand_packer #(.sig_width(23), .exp_width(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_x_i(in_x), .in_y_i(in_y), .in_last_i(in_last), .in_rnd_i(in_rnd),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_a_o(oa), .out_b_o(ob), .out_c_o(oc), .out_d_o(od), .out_e_o(oe), .out_f_o(of_),
        .out_count_o(ocount), .out_first_o(ofirst), .out_last_o(olast), .out_rnd_o(ornd)
    );

    always #5 clk = ~clk;

    function automatic grp_t mk(logic [31:0] a, b, c, d, e, f, logic [1:0] n,
                                logic fi, la, logic [2:0] r);
        grp_t g;
        g.a = a; g.b = b; g.c = c; g.d = d; g.e = e; g.f = f;
        g.count = n; g.first = fi; g.last = la; g.rnd = r;
        return g;
    endfunction

    function automatic grp_t dut_grp();
        return mk(oa, ob, oc, od, oe, of_, ocount, ofirst, olast, ornd);
    endfunction

    function automatic logic [31:0] fp(int i);
        case (i)
            1: return 32'h3F80_0000;
            2: return 32'h4000_0000;
            3: return 32'h4040_0000;
            4: return 32'h4080_0000;
            5: return 32'h40A0_0000;
            6: return 32'h40C0_0000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: group the accepted pairs by the vector/3-pair rules
    task automatic model_accept(logic [31:0] x, y, logic last, logic [2:0] r);
        grp_t g;
        if (cur_n == 0) cur_first = mvstart;
        if (mvstart) mrnd = r;
        cur_x[cur_n] = x;
        cur_y[cur_n] = y;
        cur_n++;
        mvstart = last;
        if (cur_n == 3 || last) begin
            g = mk(cur_x[0], cur_y[0],
                   cur_n > 1 ? cur_x[1] : 32'h0, cur_n > 1 ? cur_y[1] : 32'h0,
                   cur_n > 2 ? cur_x[2] : 32'h0, cur_n > 2 ? cur_y[2] : 32'h0,
                   2'(cur_n), cur_first, last, mrnd);
            expq.push_back(g);
            cur_n = 0;
        end
    endtask

    // Monitor and compare process, sampled on the falling edge
    always @(negedge clk) begin
        grp_t cur;
        if (!rst_n) begin
            expq.delete();
            cur_n = 0;
            mvstart = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (in_valid && in_ready) model_accept(in_x, in_y, in_last, in_rnd);
            cur = dut_grp();
            if (prev_stall) chk("hold_stable", 256'(cur), 256'(prev_out));
            if (out_valid && out_ready) begin
                obs.push_back(cur);
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_group: got %h expected none", cur);
                end else begin
                    chk("group", 256'(cur), 256'(expq.pop_front()));
                end
            end
            if (track_ready && in_valid && !in_ready) ready_drops++;
            prev_stall = out_valid && !out_ready;
            prev_out = cur;
        end
    end

    task automatic send(logic [31:0] x, y, logic last, logic [2:0] r);
        int k;
        in_valid = 1'b1; in_x = x; in_y = y; in_last = last; in_rnd = r;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 300) chk("send_timeout", 256'(0), 256'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x = $urandom; in_y = $urandom; in_last = 1'($urandom); in_rnd = 3'($urandom);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (expq.size() == 0 && !out_valid) break;
        end
        if (k == 300) chk("drain_timeout", 256'(0), 256'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_obs(string nm, int idx, grp_t exp);
        if (idx >= obs.size()) chk({nm, "_missing"}, 256'(obs.size()), 256'(idx + 1));
        else chk(nm, 256'(obs[idx]), 256'(exp));
    endtask

    initial begin
        int base;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_x = 32'h0; in_y = 32'h0; in_last = 1'b0; in_rnd = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 256'(dut_grp()), 256'(0));
        chk("reset_valid", 256'(out_valid), 256'(0));
        chk("reset_ready", 256'(in_ready), 256'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset recovery: partial group discarded
        send(32'h1111_0001, 32'h2222_0001, 1'b0, 3'd5);
        send(32'h1111_0002, 32'h2222_0002, 1'b0, 3'd5);
        rst_n = 1'b0;
        #2;
        chk("t1_rst_valid", 256'(out_valid), 256'(0));
        chk("t1_rst_ready", 256'(in_ready), 256'(1));
        @(negedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        base = obs.size();
        send(32'hAAAA_0001, 32'hBBBB_0001, 1'b0, 3'd3);
        send(32'hAAAA_0002, 32'hBBBB_0002, 1'b0, 3'd0);
        send(32'hAAAA_0003, 32'hBBBB_0003, 1'b1, 3'd0);
        drain();
        chk_obs("t1_group", base, mk(32'hAAAA_0001, 32'hBBBB_0001, 32'hAAAA_0002, 32'hBBBB_0002,
                                     32'hAAAA_0003, 32'hBBBB_0003, 2'd3, 1'b1, 1'b1, 3'd3));

        // 6-pair vector, continuous streaming
        base = obs.size();
        track_ready = 1'b1; ready_drops = 0;
        for (int i = 1; i <= 6; i++) send(fp(i), fp(2), i == 6, 3'd0);
        track_ready = 1'b0;
        drain();
        chk("t2_ready_drops", 256'(ready_drops), 256'(0));
        chk_obs("t2_g1", base, mk(fp(1), fp(2), fp(2), fp(2), fp(3), fp(2), 2'd3, 1'b1, 1'b0, 3'd0));
        chk_obs("t2_g2", base + 1, mk(fp(4), fp(2), fp(5), fp(2), fp(6), fp(2), 2'd3, 1'b0, 1'b1, 3'd0));

        // 4-pair vector: short final group padded with +0.0
        base = obs.size();
        for (int i = 1; i <= 4; i++) send(fp(i), fp(2), i == 4, 3'd4);
        drain();
        chk_obs("t3_g2", base + 1, mk(fp(4), fp(2), 32'h0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1, 3'd4));

        // Backpressure for 10 cycles while 7 pairs are offered
        base = obs.size();
        fork
            begin
                out_ready = 1'b0;
                repeat (9) @(posedge clk);
                @(negedge clk);
                chk("t4_ready_low", 256'(in_ready), 256'(0));
                chk("t4_valid_held", 256'(out_valid), 256'(1));
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
            for (int i = 1; i <= 7; i++) send(32'h100 + 32'(i), 32'h200 + 32'(i), i == 7, 3'd6);
        join
        drain();
        chk_obs("t4_g3", base + 2, mk(32'h107, 32'h207, 32'h0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1, 3'd6));

        // Rounding-mode capture only on the first pair of a vector
        base = obs.size();
        for (int i = 1; i <= 5; i++) send(fp(i), fp(1), i == 5, i == 1 ? 3'b001 : 3'b010);
        for (int i = 1; i <= 2; i++) send(fp(i), fp(3), i == 2, i == 1 ? 3'b010 : 3'b111);
        drain();
        chk_obs("t5_v1g1", base, mk(fp(1), fp(1), fp(2), fp(1), fp(3), fp(1), 2'd3, 1'b1, 1'b0, 3'b001));
        chk_obs("t5_v1g2", base + 1, mk(fp(4), fp(1), fp(5), fp(1), 32'h0, 32'h0, 2'd2, 1'b0, 1'b1, 3'b001));
        chk_obs("t5_v2", base + 2, mk(fp(1), fp(3), fp(2), fp(3), 32'h0, 32'h0, 2'd2, 1'b1, 1'b1, 3'b010));

        // Back-to-back single-pair vectors
        base = obs.size();
        track_ready = 1'b1; ready_drops = 0;
        for (int i = 1; i <= 5; i++) send(fp(i), fp(6), 1'b1, 3'(i));
        track_ready = 1'b0;
        drain();
        chk("t6_ready_drops", 256'(ready_drops), 256'(0));
        chk_obs("t6_g3", base + 2, mk(fp(3), fp(6), 32'h0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b1, 1'b1, 3'd3));

        // Random traffic with random backpressure and gaps
        rand_done = 1'b0;
        fork
            while (!rand_done) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    send($urandom, $urandom, (i == 299) || ($urandom_range(0, 3) == 0),
                         3'($urandom));
                end
                rand_done = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
        chk("rand_model_empty", 256'(expq.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
